// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM states and the alignment rule.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  // The reserved size is reported through the same error path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Little-endian lane handling: sub-word extraction with sign/zero extension
// for loads, and single-lane merge into a read word for sub-word stores.
module lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b      = word[{addr_lo, 3'b000} +: 8];
    lane_h      = addr_lo[1] ? word[31:16] : word[15:0];
    load_data   = word;
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        load_data = is_signed ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
        merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = is_signed ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
        if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
        else            merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port word RAM
// without byte enables; sub-word stores are done as read-modify-write.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t state, state_nxt;

  logic          we_q;
  logic          signed_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merged_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          req_bad;
  logic          word_store;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;

  assign accept     = req_valid & req_ready;
  assign req_bad    = is_misaligned(req_size, req_addr[1:0]);
  assign word_store = we_q & (size_q == SZ_WORD);

  lane_unit u_lane (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_signed   (signed_q),
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        if (word_store) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          state_nxt = RESP;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = we_q ? WRITE : RESP;
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged_q;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch at accept; read data (or merged word) captured one cycle after the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      signed_q <= req_signed;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= 32'h0;
      err_q    <= req_bad;
    end else if (state == CAPTURE) begin
      if (we_q) merged_q <= merged_word;
      else      rdata_q  <= load_data;
    end
  end

  assign mem_addr   = addr_q[AW+1:2];
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural synchronous RAM.
module tb_mem_access_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   ram [0:(1<<AW)-1];
  int            cyc = 0;
  int            wr_cnt = 0;
  int            we_cnt = 0;
  int            en_cnt = 0;
  int            wr_cyc = -1;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = 32'h0;

  int            n_assert = 0;
  int            n_fail = 0;
  int            t_acc = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
        wr_cyc <= cyc;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [AW+1:0] a, input logic [31:0] wd);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    t_acc = cyc - 1;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
    int n = 0;
    while (!resp_valid && n < 12) begin
      tick();
      n++;
    end
    chk("resp_timeout", 32'(resp_valid), 32'd1);
    lat = cyc - t_acc;
    rd  = resp_rdata;
    er  = resp_err;
    if (resp_ready) tick();
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [AW+1:0] a, input logic [31:0] exp);
    int lat; logic [31:0] rd; logic er;
    issue(1'b0, sz, sg, a, 32'h0);
    wait_resp(lat, rd, er);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [1:0] sz,
                        input logic [AW+1:0] a);
    int lat; logic [31:0] rd; logic er; int e0; int w0;
    e0 = en_cnt; w0 = wr_cnt;
    issue(we, sz, 1'b0, a, 32'hFFFF_FFFF);
    wait_resp(lat, rd, er);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, 32'(er), 32'd1);
    chk({tag, "_data"}, rd, 32'h0);
    chk({tag, "_no_mem_en"}, 32'(en_cnt - e0), 32'd0);
    chk({tag, "_no_write"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int lat; logic [31:0] rd; logic er; int w0; int e0; int wc0; int rv;

    #1;
    chk_reset_outputs("rst_async");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("rst_after");

    // word store 0xDEADBEEF at 0x010, then load it back
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    chk("sw_mem_en_t1", 32'(mem_en), 32'd1);
    chk("sw_mem_we_t1", 32'(mem_we), 32'd1);
    chk("sw_mem_addr_t1", 32'(mem_addr), 32'h4);
    chk("sw_mem_wdata_t1", mem_wdata, 32'hDEAD_BEEF);
    wait_resp(lat, rd, er);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_ram", ram[4], 32'hDEAD_BEEF);

    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    chk("lw_mem_en_t1", 32'(mem_en), 32'd1);
    chk("lw_mem_we_t1", 32'(mem_we), 32'd0);
    wait_resp(lat, rd, er);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_err", 32'(er), 32'd0);

    // sub-word loads from 0x80FF7F01 at 0x020
    preload(10'd8, 32'h80FF_7F01);
    do_load("lbu_023", 2'b00, 1'b0, 12'h023, 32'h0000_0080);
    do_load("lb_023",  2'b00, 1'b1, 12'h023, 32'hFFFF_FF80);
    do_load("lh_022",  2'b01, 1'b1, 12'h022, 32'hFFFF_80FF);
    do_load("lhu_020", 2'b01, 1'b0, 12'h020, 32'h0000_7F01);
    do_load("lb_020",  2'b00, 1'b1, 12'h020, 32'h0000_0001);

    // read-modify-write on 0x11223344 at word 0
    preload(10'd0, 32'h1122_3344);
    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 12'h001, 32'h0000_00AA);
    wait_resp(lat, rd, er);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_one_write", 32'(wr_cnt - w0), 32'd1);
    chk("sb_write_cycle", 32'(wr_cyc - t_acc), 32'd3);
    chk("sb_ram", ram[0], 32'h1122_AA44);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_err", 32'(er), 32'd0);

    w0 = wr_cnt;
    issue(1'b1, 2'b01, 1'b0, 12'h002, 32'h0000_BEEF);
    wait_resp(lat, rd, er);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_one_write", 32'(wr_cnt - w0), 32'd1);
    chk("sh_ram", ram[0], 32'hBEEF_AA44);

    // misaligned and reserved-size requests
    do_err("lh_001", 1'b0, 2'b01, 12'h001);
    do_err("lw_002", 1'b0, 2'b10, 12'h002);
    do_err("sz11_ld", 1'b0, 2'b11, 12'h000);
    do_err("sz11_st", 1'b1, 2'b11, 12'h000);
    chk("err_ram_kept", ram[0], 32'hBEEF_AA44);

    // backpressure on a load response
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    wait_resp(lat, rd, er);
    chk("bp_lat", 32'(lat), 32'd3);
    chk("bp_data", rd, 32'h80FF_7F01);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h010;
    req_valid = 1'b1;
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, 32'h80FF_7F01);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    chk("bp_no_mem", 32'(en_cnt - e0), 32'd0);
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_resp", 32'(resp_valid), 32'd0);
    chk("bp_idle_mem_en", 32'(mem_en), 32'd0);
    tick();
    req_valid = 1'b0;
    t_acc = cyc - 1;
    chk("bp2_mem_en", 32'(mem_en), 32'd1);
    chk("bp2_mem_addr", 32'(mem_addr), 32'h4);
    wait_resp(lat, rd, er);
    chk("bp2_lat", 32'(lat), 32'd3);
    chk("bp2_data", rd, 32'hDEAD_BEEF);

    // reset during CAPTURE of a byte store
    preload(10'd2, 32'h5566_7788);
    w0 = wr_cnt; wc0 = we_cnt;
    issue(1'b1, 2'b00, 1'b0, 12'h009, 32'h0000_0099);
    tick();
    chk("rmw_capture_no_en", 32'(mem_en), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    tick(); tick();
    rst_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid) rv++;
    end
    chk("rst_no_resp", 32'(rv), 32'd0);
    chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rst_no_we", 32'(we_cnt - wc0), 32'd0);
    chk("rst_ram_kept", ram[2], 32'h5566_7788);
    chk("rst_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
